// File: rtl/fpcvt_i2f.sv
// fpcvt_i2f: sequential integer -> IEEE-754 single-precision converter.
// Accepts a signed/unsigned integer, normalises it one bit per cycle,
// rounds, and presents the packed float over a valid/ready handshake.
// Build option: define FPCVT_RNE_EN for round-to-nearest-even; otherwise
// the mantissa is truncated toward zero. out_inexact is reported in both.
module fpcvt_i2f #(
  parameter int N = 32,
  parameter int M = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_inexact
);

  localparam int EB   = N - M - 1;
  localparam int KW   = $clog2(N);
  localparam int BIAS = (1 << (EB - 1)) - 1;
  localparam logic [EB-1:0] EXP_TOP = EB'(BIAS + N - 1);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t        state_q;
  logic          sign_q;
  logic [N-1:0]  mag_q;
  logic [KW-1:0] k_q;
  logic [N-1:0]  out_data_q;
  logic          out_inexact_q;
  logic          out_valid_q;

  logic          cap_sign;
  logic [N-1:0]  cap_mag;
  logic [M-1:0]  mant_raw;
  logic          guard_bit;
  logic          sticky_bit;
  logic          round_inc;
  logic [M:0]    mant_sum;
  logic [EB-1:0] exp_raw;
  logic [EB-1:0] exp_fin;

  // Capture path: sign and magnitude of the incoming operand
  always_comb begin
    cap_sign = in_signed & in_data[N-1];
    cap_mag  = cap_sign ? ((~in_data) + N'(1)) : in_data;
  end

  // Rounding datapath: mantissa/guard/sticky from the normalised magnitude
  always_comb begin
    mant_raw   = mag_q[N-2 -: M];
    guard_bit  = mag_q[N-2-M];
    sticky_bit = |mag_q[N-3-M:0];
`ifdef FPCVT_RNE_EN
    round_inc  = guard_bit & (sticky_bit | mant_raw[0]);
`else
    round_inc  = 1'b0;
`endif
    // A carry out of the mantissa leaves the field zero and bumps the exponent
    mant_sum   = {1'b0, mant_raw} + (M+1)'(round_inc);
    exp_raw    = EXP_TOP - EB'(k_q);
    exp_fin    = exp_raw + EB'(mant_sum[M]);
  end

  // Control FSM with registered result and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sign_q        <= 1'b0;
      mag_q         <= '0;
      k_q           <= '0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= cap_sign;
            mag_q  <= cap_mag;
            k_q    <= '0;
            if (cap_mag == '0) begin
              out_data_q    <= '0;
              out_inexact_q <= 1'b0;
              out_valid_q   <= 1'b1;
              state_q       <= DONE;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_q[N-1]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            k_q   <= k_q + KW'(1);
          end
        end
        ROUND: begin
          out_data_q    <= {sign_q, exp_fin, mant_sum[M-1:0]};
          out_inexact_q <= guard_bit | sticky_bit;
          out_valid_q   <= 1'b1;
          state_q       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE) & ~rst;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fpcvt_i2f.sv
// Testbench for fpcvt_i2f: table of integer operands with expected floats,
// a scoreboard queue of expected results, plus reset/backpressure sequences.
module tb_fpcvt_i2f;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  fpcvt_i2f #(.N(32), .M(23)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_signed  (in_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_inexact(out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edges: clock edges after the accept edge until out_valid is seen
  // (a zero operand shows out_valid in the very next cycle, i.e. 0 extra edges)
  typedef struct {
    logic        sgn;
    logic [31:0] din;
    logic [31:0] dout;
    logic        inex;
    int          edges;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        i;
  } exp_t;

  localparam int NV = 14;
  vec_t tbl [NV];
  exp_t sb [$];

  int n_vec;
  int n_cmp;
  int n_bad;

`ifdef FPCVT_RNE_EN
  localparam logic [31:0] R_01000003 = 32'h4B80_0002;
  localparam logic [31:0] R_FFFFFFFF = 32'h4F80_0000;
  localparam logic [31:0] R_01000007 = 32'h4B80_0004;
  localparam logic [31:0] R_10000018 = 32'h4D80_0001;
`else
  localparam logic [31:0] R_01000003 = 32'h4B80_0001;
  localparam logic [31:0] R_FFFFFFFF = 32'h4F7F_FFFF;
  localparam logic [31:0] R_01000007 = 32'h4B80_0003;
  localparam logic [31:0] R_10000018 = 32'h4D80_0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold, input bit early);
    int   edges;
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    in_signed = v.sgn;
    in_data   = v.din;
    out_ready = early;
    #1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    n_vec++;
    sb.push_back('{d: v.dout, i: v.inex});
    in_valid = 1'b0;
    in_data  = $urandom;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (!out_valid) check("busy_in_ready", 32'(in_ready), 32'd0);
    end
    check("latency", 32'(edges), 32'(v.edges));
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      in_signed = $urandom_range(0, 1);
      in_data   = $urandom;
      check("hold_data", out_data, v.dout);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: empty at output, expected 1 entry");
    end else begin
      e = sb.pop_front();
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", out_data, e.d);
      check("out_inexact", 32'(out_inexact), 32'(e.i));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_after_hs", 32'(out_valid), 32'd0);
    check("ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time exceeded, expected $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    n_vec = 0;
    n_cmp = 0;
    n_bad = 0;

    //           sgn   din            dout           inex  edges
    tbl[0]  = '{1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33};
    tbl[1]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 0};
    tbl[2]  = '{1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2};
    tbl[3]  = '{1'b0, 32'h0100_0003, R_01000003,    1'b1, 9};
    tbl[4]  = '{1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b1, 9};
    tbl[5]  = '{1'b0, 32'hFFFF_FFFF, R_FFFFFFFF,    1'b1, 2};
    tbl[6]  = '{1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33};
    tbl[7]  = '{1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33};
    tbl[8]  = '{1'b0, 32'h8000_0000, 32'h4F00_0000, 1'b0, 2};
    tbl[9]  = '{1'b1, 32'hFFFF_FF9C, 32'hC2C8_0000, 1'b0, 27};
    tbl[10] = '{1'b0, 32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0, 10};
    tbl[11] = '{1'b0, 32'h0100_0007, R_01000007,    1'b1, 9};
    tbl[12] = '{1'b0, 32'h1000_0018, R_10000018,    1'b1, 5};
    tbl[13] = '{1'b0, 32'h0100_0005, 32'h4B80_0002, 1'b1, 9};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_inexact", 32'(out_inexact), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Table run; vector 3 is held under backpressure, 1 and 5 see early out_ready
    for (int i = 0; i < NV; i++)
      run_vec(tbl[i], (i == 3) ? 10 : 0, (i == 1 || i == 5));

    // Reset in the middle of normalisation discards the conversion
    @(negedge clk);
    in_valid  = 1'b1;
    in_signed = 1'b0;
    in_data   = 32'h0000_0001;
    @(posedge clk);
    #1;
    n_vec++;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_output", 32'(seen), 32'd0);

    // Converter still works after the mid-flight reset
    run_vec(tbl[2], 0, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
